mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port shared data memory between NUM_CORES processor cores and the host communication port.
- The host port carries the load and unload bursts; the cores carry run-time accesses.
- The host has absolute priority. Cores are served round-robin, one access per grant, and masked cores are skipped.
- Sits between the cores/comm controller and the data memory inside the top-level processor.

Parameters:
- NUM_CORES, 4, number of core requesters.
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_en  in  NUM_CORES  per-core enable mask; requests from cleared bits are ignored.
- core_req  in  NUM_CORES  per-core access request; held until granted.
- core_we  in  NUM_CORES  per-core write flag.
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed write data.
- core_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as the accepted request.
- core_rvalid  out  NUM_CORES  registered; read data valid for core i.
- com_req, com_we  in  1 each  host request and write flag.
- com_addr  in  ADDR_W  host address.
- com_wdata  in  DATA_W  host write data.
- com_gnt  out  1  host grant, combinational.
- com_rvalid  out  1  registered; host read data valid.
- rdata  out  DATA_W  broadcast read data, equal to mem_rdata.
- mem_en, mem_we  out  1 each  registered memory strobes.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All gnt, rvalid, mem_en and mem_we outputs are 0.
  - mem_addr and mem_wdata are 0.
  - Reset mid-access drops the access; no rvalid is produced for it.
- FSM states: IDLE, CORE, HOST.
  - IDLE/CORE -> HOST when com_req=1 (subject to the lock rule under Optional Feature).
  - HOST: com_gnt=com_req. HOST -> IDLE when com_req=0. No core is granted while in HOST.
  - IDLE -> CORE when any (core_req & core_en) is set. CORE -> IDLE when none are set.
- Round-robin selection:
  - The winner is the first enabled requester at or after rr_ptr, scanning upward modulo NUM_CORES.
  - After a grant to core k, rr_ptr <= (k+1) mod NUM_CORES. Wrap from NUM_CORES-1 goes to 0.
  - Exactly one grant per cycle at most.
- Simultaneous events:
  - Host and core requests in the same cycle: the host wins and rr_ptr is unchanged.
  - A core request withdrawn before grant is not served.
- Latency:
  - Cycle T: grant.
  - T+1: mem_en=1, with mem_we, mem_addr and mem_wdata registered from the granted port.
  - T+2: for reads, the granted port's rvalid=1 for exactly one cycle, with rdata=mem_rdata.
  - Writes produce no rvalid.
- Throughput: back-to-back grants are allowed every cycle. With all NUM_CORES cores requesting continuously, each is served once every NUM_CORES cycles.
- No requests: mem_en=0, and the remaining mem_* outputs hold their last values.
- core_en change takes effect in the same cycle. An outstanding rvalid of a core that was just disabled is still delivered.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input core_lock[NUM_CORES].
  - If the granted core has core_lock=1, it keeps ownership in subsequent cycles. Only its requests are granted and rr_ptr is frozen. This allows atomic read-modify-write.
  - Ownership is released on the first cycle the owner has core_lock=0.
  - The host waits until release, then preempts.
  - rst_n clears ownership.
- Undefined: the port is absent and every grant is single-access.

Decomposition:
- Package mc_arb_pkg: state enum (IDLE, CORE, HOST) and the ADDR_W/DATA_W defaults.
- Sub-module rr_picker: combinational. Inputs are req vector and ptr; outputs are one-hot grant and valid.

Test Plan:
- Core 2 reads addr 0x0010; memory holds 0xBEEF there -> core_gnt=0100 at T, mem_addr=0x0010 at T+1, core_rvalid[2]=1 and rdata=0xBEEF at T+2.
- All 4 cores request continuously, rr_ptr=0 -> grant sequence 0,1,2,3,0,1.
- Host and core 1 request in the same cycle; host burst of 8 writes -> com_gnt for 8 cycles, no core_gnt, then core 1 is granted.
- core_en=1010 with all cores requesting -> grants alternate 1,3 only.
- rst_n pulsed low at T+1 of a read -> no rvalid, rr_ptr=0, and all outputs are 0 asynchronously.
- ARB_LOCK_EN: core 0 locks for 3 accesses while host and core 1 are pending -> 3 grants to core 0, then host, then core 1.

Source files
------------

// File: rtl/mc_arb_pkg.sv
// Shared constants for the data-memory port arbiter: default widths and FSM state codes.
package mc_arb_pkg;

    localparam int ARB_NUM_CORES = 4;
    localparam int ARB_ADDR_W    = 16;
    localparam int ARB_DATA_W    = 16;

    // Arbiter FSM state set (IDLE, CORE, HOST)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_HOST = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, scanning upward with wrap.
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    int idx_s;

    // Scan offsets 0..N-1 from ptr and keep only the first hit
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx_s = 0;
        for (int i = 0; i < N; i++) begin
            idx_s = (int'(ptr) + i) % N;
            if (!valid && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                valid      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared data memory: host has absolute priority, cores served round-robin.
// Optional core ownership lock for atomic read-modify-write is enabled with `define ARB_LOCK_EN.
module mem_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int NUM_CORES = ARB_NUM_CORES,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_en,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        core_lock,
`endif
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    input  logic                        com_req,
    input  logic                        com_we,
    input  logic [ADDR_W-1:0]           com_addr,
    input  logic [DATA_W-1:0]           com_wdata,
    output logic                        com_gnt,
    output logic                        com_rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [1:0]           state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    // Bit NUM_CORES tracks the host; lower bits track cores
    logic [NUM_CORES:0]   rd_pend_q, rd_pend_d;
    logic [NUM_CORES:0]   rvalid_q, rvalid_d;

    logic                 lock_hold_s;
    logic [NUM_CORES-1:0] lock_mask_s;
    logic [NUM_CORES-1:0] elig_s;
    logic [NUM_CORES-1:0] pick_gnt_s;
    logic                 pick_vld_s;
    logic                 host_go_s;
    logic                 core_ok_s;
    logic                 core_any_s;
    logic [PTR_W-1:0]     gnt_idx_s;
    int                   gnt_sel_s;

`ifdef ARB_LOCK_EN
    logic                 own_vld_q, own_vld_d;
    logic [PTR_W-1:0]     own_idx_q, own_idx_d;

    // Ownership is live only while the owner keeps its lock bit high
    always_comb begin
        lock_hold_s = own_vld_q & core_lock[own_idx_q];
        lock_mask_s = '0;
        if (lock_hold_s) begin
            lock_mask_s[own_idx_q] = 1'b1;
        end else begin
            lock_mask_s = '1;
        end
    end

    // Ownership next-state: keep while held, take on a locked grant, otherwise drop
    always_comb begin
        own_vld_d = own_vld_q;
        own_idx_d = own_idx_q;
        if (lock_hold_s) begin
            own_vld_d = 1'b1;
        end else if (core_any_s && core_lock[gnt_idx_s]) begin
            own_vld_d = 1'b1;
            own_idx_d = gnt_idx_s;
        end else begin
            own_vld_d = 1'b0;
        end
    end

    // Ownership registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_vld_q <= 1'b0;
            own_idx_q <= '0;
        end else begin
            own_vld_q <= own_vld_d;
            own_idx_q <= own_idx_d;
        end
    end
`else
    // Every grant is single-access in this build
    always_comb begin
        lock_hold_s = 1'b0;
        lock_mask_s = '1;
    end
`endif

    assign elig_s = core_req & core_en & lock_mask_s;

    rr_picker #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (elig_s),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt_s),
        .valid (pick_vld_s)
    );

    // Grant steering: host first unless a core holds the lock; nothing granted in reset
    always_comb begin
        host_go_s = 1'b0;
        core_ok_s = 1'b0;
        if (!rst_n) begin
            host_go_s = 1'b0;
        end else if (state_q == ST_HOST) begin
            host_go_s = com_req;
        end else if (com_req && !lock_hold_s) begin
            host_go_s = 1'b1;
        end else begin
            core_ok_s = 1'b1;
        end
    end

    assign core_gnt   = core_ok_s ? pick_gnt_s : '0;
    assign core_any_s = core_ok_s & pick_vld_s;
    assign com_gnt    = host_go_s;

    // One-hot to index of the granted core
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_gnt_s[i]) begin
                gnt_idx_s = PTR_W'(i);
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    assign gnt_sel_s = int'(gnt_idx_s);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_CORE: begin
                if (host_go_s) begin
                    state_d = ST_HOST;
                end else if (|(core_req & core_en)) begin
                    state_d = ST_CORE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (com_req) begin
                    state_d = ST_HOST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer advances past a freshly granted core; frozen while a lock is held
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (core_any_s && !lock_hold_s) begin
            if (gnt_idx_s == PTR_W'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + PTR_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Memory command capture; address/data/we hold when idle
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_pend_d   = '0;
        if (host_go_s) begin
            mem_en_d             = 1'b1;
            mem_we_d             = com_we;
            mem_addr_d           = com_addr;
            mem_wdata_d          = com_wdata;
            rd_pend_d[NUM_CORES] = ~com_we;
        end else if (core_any_s) begin
            mem_en_d             = 1'b1;
            mem_we_d             = core_we[gnt_idx_s];
            mem_addr_d           = core_addr[gnt_sel_s*ADDR_W +: ADDR_W];
            mem_wdata_d          = core_wdata[gnt_sel_s*DATA_W +: DATA_W];
            rd_pend_d[gnt_idx_s] = ~core_we[gnt_idx_s];
        end else begin
            mem_en_d = 1'b0;
        end
    end

    assign rvalid_d = rd_pend_q;

    // State, pointer and memory-side pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_rvalid = rvalid_q[NUM_CORES-1:0];
    assign com_rvalid  = rvalid_q[NUM_CORES];
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan steps plus random traffic
// compared cycle by cycle with a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  core_en, core_req, core_we, core_lock;
    logic [63:0] core_addr, core_wdata;
    logic [3:0]  core_gnt, core_rvalid;
    logic        com_req, com_we, com_gnt, com_rvalid;
    logic [15:0] com_addr, com_wdata, rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_en(core_en), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
`ifdef ARB_LOCK_EN
        .core_lock(core_lock),
`endif
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .com_req(com_req), .com_we(com_we), .com_addr(com_addr), .com_wdata(com_wdata),
        .com_gnt(com_gnt), .com_rvalid(com_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Preset memory image; address 0x10 holds 0xBEEF
    function automatic logic [15:0] mem_init(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : (16'hA000 ^ {8'h00, a});
    endfunction

    logic [15:0] tb_dat [256];
    bit          tb_wr  [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                tb_dat[mem_addr[7:0]] <= mem_wdata;
                tb_wr[mem_addr[7:0]]  <= 1'b1;
            end else begin
                mem_rdata <= tb_wr[mem_addr[7:0]] ? tb_dat[mem_addr[7:0]] : mem_init(mem_addr[7:0]);
            end
        end
    end

    int n_pass = 0, n_total = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          m_ptr, m_owner;
    bit          m_host;
    bit          s1_v, s1_we;  int s1_port; logic [15:0] s1_addr;
    bit          s2_v;         int s2_port; logic [15:0] s2_data;
    logic        m_we;         logic [15:0] m_addr, m_wdata;
    logic [15:0] ref_dat [256];
    bit          ref_wr  [256];
    logic [3:0]  snap_cg, snap_rv;
    logic        snap_com, snap_en;
    logic [15:0] snap_addr, snap_rdata;

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_host = 1'b0;
        s1_v = 1'b0; s1_we = 1'b0; s1_port = 0; s1_addr = 16'h0000;
        s2_v = 1'b0; s2_port = 0; s2_data = 16'h0000;
        m_we = 1'b0; m_addr = 16'h0000; m_wdata = 16'h0000;
    endtask

    // One clock: check DUT against model at negedge, advance model, return 1ns after posedge
    task automatic step();
        int eg; bit egc; bit locked; logic [3:0] exp_cg, exp_rv;
        @(negedge clk);
        locked = (m_owner >= 0) && core_lock[m_owner];
        egc = 1'b0; eg = -1;
        if (m_host) egc = com_req;
        else if (com_req && !locked) egc = 1'b1;
        else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (eg < 0 && core_req[c] && core_en[c] && (!locked || c == m_owner)) eg = c;
            end
        end
        exp_cg = (eg >= 0) ? (4'b0001 << eg) : 4'b0000;
        exp_rv = (s2_v && s2_port < 4) ? (4'b0001 << s2_port) : 4'b0000;
        snap_cg = core_gnt; snap_com = com_gnt; snap_en = mem_en; snap_addr = mem_addr;
        snap_rv = core_rvalid; snap_rdata = rdata;
        chk("core_gnt", {60'd0, core_gnt}, {60'd0, exp_cg});
        chk("com_gnt", {63'd0, com_gnt}, {63'd0, egc});
        chk("mem_en", {63'd0, mem_en}, {63'd0, s1_v});
        chk("mem_we", {63'd0, mem_we}, {63'd0, m_we});
        chk("mem_addr", {48'd0, mem_addr}, {48'd0, m_addr});
        chk("mem_wdata", {48'd0, mem_wdata}, {48'd0, m_wdata});
        chk("core_rvalid", {60'd0, core_rvalid}, {60'd0, exp_rv});
        chk("com_rvalid", {63'd0, com_rvalid}, {63'd0, (s2_v && s2_port == 4)});
        if (s2_v) chk("rdata", {48'd0, rdata}, {48'd0, s2_data});
        // advance pipeline: s1 executes in memory this edge
        s2_v = s1_v && !s1_we; s2_port = s1_port;
        if (s1_v && s1_we) begin
            ref_dat[s1_addr[7:0]] = m_wdata; ref_wr[s1_addr[7:0]] = 1'b1;
        end else if (s1_v) begin
            s2_data = ref_wr[s1_addr[7:0]] ? ref_dat[s1_addr[7:0]] : mem_init(s1_addr[7:0]);
        end
        s1_v = egc || (eg >= 0);
        if (egc) begin
            s1_we = com_we; s1_port = 4; m_we = com_we; m_addr = com_addr; m_wdata = com_wdata;
        end else if (eg >= 0) begin
            s1_we = core_we[eg]; s1_port = eg; m_we = core_we[eg];
            m_addr = core_addr[eg*16 +: 16]; m_wdata = core_wdata[eg*16 +: 16];
        end
        s1_addr = m_addr;
        m_host = egc;
        if (eg >= 0 && !locked) m_ptr = (eg + 1) % 4;
        if (!locked) m_owner = (eg >= 0 && core_lock[eg]) ? eg : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input bit req, input bit we,
                            input logic [15:0] a, input logic [15:0] d);
        core_req[i] = req; core_we[i] = we;
        core_addr[i*16 +: 16] = a; core_wdata[i*16 +: 16] = d;
    endtask

    initial begin
        int got;
        rst_n = 1'b0; core_en = 4'b1111; core_req = 4'b0000; core_we = 4'b0000; core_lock = 4'b0000;
        core_addr = 64'd0; core_wdata = 64'd0;
        com_req = 1'b0; com_we = 1'b0; com_addr = 16'h0000; com_wdata = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
        chk("rst_rvalid", {59'd0, com_rvalid, core_rvalid}, 64'd0);
        rst_n = 1'b1;

        // Core 2 reads 0x0010
        set_core(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step();
        chk("t1_gnt", {60'd0, snap_cg}, 64'h4);
        set_core(2, 1'b0, 1'b0, 16'h0010, 16'h0000);
        step();
        chk("t1_en", {63'd0, snap_en}, 64'd1);
        chk("t1_addr", {48'd0, snap_addr}, 64'h0010);
        step();
        chk("t1_rvalid", {60'd0, snap_rv}, 64'h4);
        chk("t1_rdata", {48'd0, snap_rdata}, 64'hBEEF);

        // Reset during T+1 of a read
        set_core(2, 1'b1, 1'b0, 16'h0020, 16'h0000);
        step();
        chk("rst_pre_en", {63'd0, mem_en}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", {27'd0, core_gnt, com_gnt, core_rvalid, com_rvalid, mem_en, mem_we,
                         mem_addr, mem_wdata}, 64'd0);
        model_reset();
        core_req = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // All cores continuously: 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 16'(16'h0040 + i), 16'h0000);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_seq", {60'd0, snap_cg}, 64'(4'b0001 << (i % 4)));
        end
        core_req = 4'b0000;
        step();

        // Host burst of 8 writes with core 1 pending
        set_core(1, 1'b1, 1'b0, 16'h0080, 16'h0000);
        com_req = 1'b1; com_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            com_addr = 16'(16'h0090 + i); com_wdata = 16'(16'h5500 + i);
            step();
            chk("t3_host", {59'd0, snap_com, snap_cg}, 64'h10);
        end
        com_req = 1'b0;
        got = 0;
        for (int i = 0; i < 3 && got == 0; i++) begin
            step();
            if (snap_cg == 4'b0010) got = 1;
        end
        chk("t3_core1", 64'(got), 64'd1);
        core_req = 4'b0000;
        step();

        // Enable mask 1010: grants alternate 3,1
        core_en = 4'b1010;
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 16'(16'h00A0 + i), 16'(16'h7700 + i));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_mask", {60'd0, snap_cg}, (i % 2 == 0) ? 64'h8 : 64'h2);
        end
        core_req = 4'b0000; core_en = 4'b1111;
        repeat (2) step();

`ifdef ARB_LOCK_EN
        // Core 0 locks for 3 accesses while host and core 1 wait
        set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0000); core_lock[0] = 1'b1;
        step();
        chk("lk_g0", {59'd0, snap_com, snap_cg}, 64'h1);
        com_req = 1'b1; com_we = 1'b0; com_addr = 16'h00C0;
        set_core(1, 1'b1, 1'b0, 16'h00C1, 16'h0000);
        set_core(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
        step();
        chk("lk_g1", {59'd0, snap_com, snap_cg}, 64'h1);
        step();
        chk("lk_g2", {59'd0, snap_com, snap_cg}, 64'h1);
        core_lock[0] = 1'b0; core_req[0] = 1'b0;
        step();
        chk("lk_host", {59'd0, snap_com, snap_cg}, 64'h10);
        com_req = 1'b0;
        got = 0;
        for (int i = 0; i < 3 && got == 0; i++) begin
            step();
            if (snap_cg == 4'b0010) got = 1;
        end
        chk("lk_core1", 64'(got), 64'd1);
        core_req = 4'b0000;
        repeat (2) step();
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_core(i, ($urandom % 3) != 0, $urandom % 2, 16'($urandom), 16'($urandom));
                core_en[i] = ($urandom % 8) != 0;
`ifdef ARB_LOCK_EN
                core_lock[i] = ($urandom % 4) == 0;
`endif
            end
            if (com_req) com_req = ($urandom % 4) != 0;
            else com_req = ($urandom % 10) == 0;
            com_we = $urandom % 2; com_addr = 16'($urandom); com_wdata = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
